// File: rtl/philv_mc_core.sv
// Multi-cycle RV-subset core: one instruction walks START/FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// over a single request/ready memory port; illegal or misaligned work parks the core in HALT.
module philv_mc_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstb,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] opa, opb, imm_r, res;

  // field split and instruction class
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];

  logic is_r, is_i, is_lui, is_lw, is_sw, is_br, is_jal;
  assign is_r   = opc == 7'b0110011;
  assign is_i   = opc == 7'b0010011;
  assign is_lui = opc == 7'b0110111;
  assign is_lw  = opc == 7'b0000011;
  assign is_sw  = opc == 7'b0100011;
  assign is_br  = opc == 7'b1100011;
  assign is_jal = opc == 7'b1101111;

  // shift immediates: shamt widens to 6 bits only when XLEN is 64
  logic sh_ok, r_ok, i_ok, legal;
  assign sh_ok = (ir[31:26] == 6'b000000 || (f3 == 3'b101 && ir[31:26] == 6'b010000)) &&
                 (XLEN == 64 || !ir[25]);
  assign r_ok  = is_r && (f7 == 7'b0000000 ||
                          (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
  assign i_ok  = is_i && ((f3 != 3'b001 && f3 != 3'b101) || sh_ok);
  assign legal = r_ok || i_ok || is_lui || is_jal ||
                 ((is_lw || is_sw) && f3 == 3'b010) || (is_br && f3[2:1] == 2'b00);

  logic [XLEN-1:0] imm_d;
  always_comb begin
    imm_d = XLEN'($signed(ir[31:20]));
    if (is_sw)  imm_d = XLEN'($signed({ir[31:25], ir[11:7]}));
    if (is_br)  imm_d = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    if (is_lui) imm_d = XLEN'($signed({ir[31:12], 12'b0}));
    if (is_jal) imm_d = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
  end

  // ALU works on latched operands; bit 30 selects SUB/SRA only where it is an opcode bit
  logic [XLEN-1:0] alu_b, alu, ex_res, addr, pc4, br_pc, wb_pc, ld_data;
  logic [SHW-1:0]  sh;
  logic            alt;
  assign alu_b = is_r ? opb : imm_r;
  assign sh    = alu_b[SHW-1:0];
  assign alt   = ir[30] && (is_r || f3 == 3'b101);
  always_comb begin
    alu = opa + alu_b;
    case (f3)
      3'b000: alu = alt ? opa - alu_b : opa + alu_b;
      3'b001: alu = opa << sh;
      3'b010: alu = XLEN'($signed(opa) < $signed(alu_b));
      3'b011: alu = XLEN'(opa < alu_b);
      3'b100: alu = opa ^ alu_b;
      3'b101: alu = alt ? XLEN'($signed(opa) >>> sh) : opa >> sh;
      3'b110: alu = opa | alu_b;
      3'b111: alu = opa & alu_b;
      default: alu = opa + alu_b;
    endcase
  end

  assign pc4     = pc + XLEN'(4);
  assign ex_res  = is_lui ? imm_r : (is_jal ? pc4 : alu);
  assign addr    = opa + imm_r;
  assign br_pc   = ((opa == opb) ^ f3[0]) ? pc + imm_r : pc4;
  assign wb_pc   = is_jal ? pc + imm_r : pc4;
  assign ld_data = XLEN'($signed(mem_rdata[31:0]));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_START;
      pc        <= RESET_PC;
      ir        <= '0;
      halted    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      opa       <= '0;
      opb       <= '0;
      imm_r     <= '0;
      res       <= '0;
    end else begin
      case (state)
        S_START: begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          state    <= S_FETCH;
        end
        S_FETCH: if (mem_ready) begin
          ir      <= mem_rdata[31:0];
          mem_req <= 1'b0;
          state   <= S_DECODE;
        end
        S_DECODE: if (!legal) begin
          halted <= 1'b1;
          state  <= S_HALT;
        end else begin
          opa   <= (rs1 == 5'd0) ? '0 : rf[rs1];
          opb   <= (rs2 == 5'd0) ? '0 : rf[rs2];
          imm_r <= imm_d;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_br) begin
            pc       <= br_pc;
            mem_req  <= 1'b1;
            mem_addr <= br_pc;
            state    <= S_FETCH;
          end else if (is_lw || is_sw) begin
            if (addr[1:0] != 2'b00) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_sw;
              mem_addr  <= addr;
              mem_wdata <= opb;
              state     <= S_MEM;
            end
          end else begin
            res   <= ex_res;
            state <= S_WB;
          end
        end
        S_MEM: if (mem_ready) begin
          mem_we <= 1'b0;
          if (is_sw) begin
            pc       <= pc4;
            mem_addr <= pc4;
            state    <= S_FETCH;
          end else begin
            mem_req <= 1'b0;
            res     <= ld_data;
            state   <= S_WB;
          end
        end
        S_WB: begin
          pc       <= wb_pc;
          mem_req  <= 1'b1;
          mem_addr <= wb_pc;
          state    <= S_FETCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB && rd != 5'd0) begin
      rf[rd] <= res;
    end
  end

  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
endmodule

// File: tb/tb_philv_mc_core.sv
// Directed bench for philv_mc_core: small hand-assembled programs, cycle-exact bus checks.
module tb_philv_mc_core;
  logic        clk = 1'b0;
  logic        rstb;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_data;
  logic [4:0]  dbg_addr;

  logic [31:0] mem [0:63];
  logic        st_vld = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  int          st_cnt = 0;
  int          nerr = 0, nchk = 0;
  logic [31:0] v;

  philv_mc_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstb(rstb), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .halted(halted), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // stores land in a side record that shadows the program image on reads
  assign mem_rdata = (st_vld && mem_addr == st_addr) ? st_data : mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      st_vld  <= 1'b1;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
      st_cnt  <= st_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rdreg(input logic [4:0] a, output logic [31:0] val);
    dbg_addr = a; #1; val = dbg_data;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic enter_reset();
    @(negedge clk); rstb = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic leave_reset();
    @(negedge clk); rstb = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; mem_ready = 1'b1; dbg_addr = 5'd0;

    // ADDI x1,x0,5 ; ADDI x2,x0,7 ; ADD x3,x1,x2 ; illegal
    clear_mem();
    mem[0] = 32'h00500093; mem[1] = 32'h00700113; mem[2] = 32'h002081B3;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    leave_reset();
    tick();
    chk("f0_req", {31'b0, mem_req}, 32'd1);
    chk("f0_addr", mem_addr, 32'h0);
    chk("f0_we", {31'b0, mem_we}, 32'd0);
    repeat (4) tick();
    chk("i1_pc", pc, 32'd4);
    chk("i1_addr", mem_addr, 32'd4);
    rdreg(5'd1, v); chk("x1", v, 32'd5);
    repeat (4) tick();
    chk("i2_pc", pc, 32'd8);
    rdreg(5'd2, v); chk("x2", v, 32'd7);
    repeat (4) tick();
    chk("i3_pc", pc, 32'd12);
    chk("i3_req", {31'b0, mem_req}, 32'd1);
    rdreg(5'd3, v); chk("x3", v, 32'd12);
    tick();
    chk("ill_dec_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("ill_halted", {31'b0, halted}, 32'd1);
    chk("ill_pc", pc, 32'd12);
    repeat (3) tick();
    chk("ill_hold_req", {31'b0, mem_req}, 32'd0);
    chk("ill_hold_pc", pc, 32'd12);

    // ADDI x3,x0,12 ; SW x3,0x40(x0) ; LW x4,0x40(x0) ; illegal -- 3 wait cycles per MEM
    enter_reset();
    clear_mem();
    mem[0] = 32'h00C00193; mem[1] = 32'h04302023; mem[2] = 32'h04002203;
    leave_reset();
    tick();
    repeat (4) tick();
    chk("sw_fetch_addr", mem_addr, 32'd4);
    tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_req", {31'b0, mem_req}, 32'd1);
      chk("sw_we", {31'b0, mem_we}, 32'd1);
      chk("sw_addr", mem_addr, 32'h40);
      chk("sw_wdata", mem_wdata, 32'd12);
    end
    mem_ready = 1'b1;
    tick();
    chk("sw_next_pc", pc, 32'd8);
    chk("sw_next_addr", mem_addr, 32'd8);
    chk("sw_next_we", {31'b0, mem_we}, 32'd0);
    chk("st_cnt", st_cnt, 32'd1);
    chk("st_addr", st_addr, 32'h40);
    chk("st_data", st_data, 32'd12);
    tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_req", {31'b0, mem_req}, 32'd1);
      chk("lw_we", {31'b0, mem_we}, 32'd0);
      chk("lw_addr", mem_addr, 32'h40);
    end
    mem_ready = 1'b1;
    tick();
    chk("lw_wb_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("lw_next_pc", pc, 32'd12);
    rdreg(5'd4, v); chk("x4", v, 32'd12);

    // ADDI x1,x0,3 ; BEQ x1,x1,+8 ; (skip) ; BNE x1,x1,+8 ; BNE x1,x0,+8 ; (skip) ; illegal
    enter_reset();
    clear_mem();
    mem[0] = 32'h00300093; mem[1] = 32'h00108463; mem[3] = 32'h00109463;
    mem[4] = 32'h00009463;
    leave_reset();
    tick();
    repeat (4) tick();
    chk("br_start_pc", pc, 32'd4);
    repeat (3) tick();
    chk("beq_pc", pc, 32'd12);
    chk("beq_addr", mem_addr, 32'd12);
    chk("beq_req", {31'b0, mem_req}, 32'd1);
    repeat (3) tick();
    chk("bne_nt_pc", pc, 32'd16);
    repeat (3) tick();
    chk("bne_t_pc", pc, 32'd24);
    repeat (2) tick();
    chk("br_halted", {31'b0, halted}, 32'd1);

    // ALU spread, x0 write discard, LUI and JAL
    enter_reset();
    clear_mem();
    mem[0]  = 32'h00100013; mem[1]  = 32'h00100093; mem[2]  = 32'h401002B3;
    mem[3]  = 32'h01C2D313; mem[4]  = 32'h0012A3B3; mem[5]  = 32'h0012B433;
    mem[6]  = 32'hFFF0C493; mem[7]  = 32'h12345537; mem[8]  = 32'h008005EF;
    mem[10] = 32'h01F09613; mem[11] = 32'h41F65693; mem[12] = 32'h00A4F733;
    mem[13] = 32'h00C0E7B3;
    leave_reset();
    tick();
    for (int i = 0; i < 200 && !halted; i++) tick();
    chk("alu_halted", {31'b0, halted}, 32'd1);
    chk("alu_pc", pc, 32'd56);
    rdreg(5'd0,  v); chk("x0", v, 32'h0);
    rdreg(5'd5,  v); chk("sub", v, 32'hFFFFFFFF);
    rdreg(5'd6,  v); chk("srli", v, 32'h0000000F);
    rdreg(5'd7,  v); chk("slt", v, 32'h1);
    rdreg(5'd8,  v); chk("sltu", v, 32'h0);
    rdreg(5'd9,  v); chk("xori", v, 32'hFFFFFFFE);
    rdreg(5'd10, v); chk("lui", v, 32'h12345000);
    rdreg(5'd11, v); chk("jal_link", v, 32'd36);
    rdreg(5'd12, v); chk("slli", v, 32'h80000000);
    rdreg(5'd13, v); chk("srai", v, 32'hFFFFFFFF);
    rdreg(5'd14, v); chk("and", v, 32'h12345000);
    rdreg(5'd15, v); chk("or", v, 32'h80000001);

    // ADDI x2,x0,9 ; LW x4,0x40(x0) -- reset lands during the MEM wait
    enter_reset();
    clear_mem();
    mem[0] = 32'h00900113; mem[1] = 32'h04002203;
    leave_reset();
    tick();
    repeat (4) tick();
    rdreg(5'd2, v); chk("x2_pre", v, 32'd9);
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("mr_req", {31'b0, mem_req}, 32'd1);
    chk("mr_addr", mem_addr, 32'h40);
    #2 rstb = 1'b0;
    #1;
    chk("mr_req_drop", {31'b0, mem_req}, 32'd0);
    chk("mr_pc", pc, 32'h0);
    rdreg(5'd2, v); chk("mr_x2_clr", v, 32'd0);
    mem_ready = 1'b1;
    leave_reset();
    tick();
    chk("mr_refetch_req", {31'b0, mem_req}, 32'd1);
    chk("mr_refetch_addr", mem_addr, 32'h0);

    // LW x4,2(x0): misaligned, must halt without a bus request
    enter_reset();
    clear_mem();
    mem[0] = 32'h00202203;
    leave_reset();
    tick();
    tick(); tick();
    chk("mis_ex_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("mis_halted", {31'b0, halted}, 32'd1);
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_pc", pc, 32'h0);
    tick();
    chk("mis_hold_req", {31'b0, mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
